// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a data port share one
// single-ported memory. Round-robin on ties, fixed MEM_LAT access cycles,
// followed by a one-cycle DONE state that pulses the winner's ack.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned DW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [DW-1:0] if_adr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [DW-1:0] d_adr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic [DW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = 4;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_grant_q, last_grant_d;
  logic          cur_d_q, cur_d_d;
  logic          we_q, we_d;

  logic          if_ack_d, d_ack_d;
  logic [DW-1:0] if_rdata_d, d_rdata_d;
  logic [DW-1:0] mem_adr_d, mem_wdata_d;
  logic          mem_read_d, mem_write_d;
  logic          grant_d_c;

  // Next-state, arbitration and registered-output values
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    cur_d_d      = cur_d_q;
    we_d         = we_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    if_rdata_d   = if_rdata;
    d_rdata_d    = d_rdata;
    mem_adr_d    = mem_adr;
    mem_wdata_d  = mem_wdata;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;

    // Data wins when alone, or on a tie when fetch was served last
    grant_d_c = d_req && (!if_req || (last_grant_q == GRANT_I));

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          state_d      = ACCESS;
          cnt_d        = CNT_LOAD;
          last_grant_d = grant_d_c ? GRANT_D : GRANT_I;
          cur_d_d      = grant_d_c;
          if (grant_d_c) begin
            mem_adr_d   = d_adr;
            mem_wdata_d = d_wdata;
            we_d        = d_we;
          end else begin
            mem_adr_d   = if_adr;
            we_d        = 1'b0;
          end
          mem_read_d  = !we_d;
          // With a single access cycle the first one is also the last
          mem_write_d = we_d && (CNT_LOAD == '0);
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!we_q) begin
            if (cur_d_q) d_rdata_d  = mem_rdata;
            else         if_rdata_d = mem_rdata;
          end
          if_ack_d = !cur_d_q;
          d_ack_d  = cur_d_q;
        end else begin
          cnt_d       = cnt_q - CW'(1);
          mem_read_d  = !we_q;
          mem_write_d = we_q && (cnt_q == CW'(1));
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= GRANT_I;
      cur_d_q      <= 1'b0;
      we_q         <= 1'b0;
      if_ack       <= 1'b0;
      d_ack        <= 1'b0;
      if_rdata     <= '0;
      d_rdata      <= '0;
      mem_adr      <= '0;
      mem_wdata    <= '0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      cur_d_q      <= cur_d_d;
      we_q         <= we_d;
      if_ack       <= if_ack_d;
      d_ack        <= d_ack_d;
      if_rdata     <= if_rdata_d;
      d_rdata      <= d_rdata_d;
      mem_adr      <= mem_adr_d;
      mem_wdata    <= mem_wdata_d;
      mem_read     <= mem_read_d;
      mem_write    <= mem_write_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1 and one
// with MEM_LAT=3, each attached to a small behavioural memory.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // MEM_LAT=1 instance signals
  logic        if_req_1, d_req_1, d_we_1;
  logic [31:0] if_adr_1, d_adr_1, d_wdata_1;
  logic        if_ack_1, d_ack_1, mem_read_1, mem_write_1;
  logic [31:0] if_rdata_1, d_rdata_1, mem_adr_1, mem_wdata_1, mem_rdata_1;

  // MEM_LAT=3 instance signals
  logic        if_req_3, d_req_3, d_we_3;
  logic [31:0] if_adr_3, d_adr_3, d_wdata_3;
  logic        if_ack_3, d_ack_3, mem_read_3, mem_write_3;
  logic [31:0] if_rdata_3, d_rdata_3, mem_adr_3, mem_wdata_3, mem_rdata_3;

  mem_port_arbiter #(.MEM_LAT(1), .DW(32)) u1 (
    .clk(clk), .rst(rst),
    .if_req(if_req_1), .if_adr(if_adr_1), .if_ack(if_ack_1), .if_rdata(if_rdata_1),
    .d_req(d_req_1), .d_we(d_we_1), .d_adr(d_adr_1), .d_wdata(d_wdata_1),
    .d_ack(d_ack_1), .d_rdata(d_rdata_1),
    .mem_adr(mem_adr_1), .mem_wdata(mem_wdata_1), .mem_read(mem_read_1),
    .mem_write(mem_write_1), .mem_rdata(mem_rdata_1)
  );

  mem_port_arbiter #(.MEM_LAT(3), .DW(32)) u3 (
    .clk(clk), .rst(rst),
    .if_req(if_req_3), .if_adr(if_adr_3), .if_ack(if_ack_3), .if_rdata(if_rdata_3),
    .d_req(d_req_3), .d_we(d_we_3), .d_adr(d_adr_3), .d_wdata(d_wdata_3),
    .d_ack(d_ack_3), .d_rdata(d_rdata_3),
    .mem_adr(mem_adr_3), .mem_wdata(mem_wdata_3), .mem_read(mem_read_3),
    .mem_write(mem_write_3), .mem_rdata(mem_rdata_3)
  );

  // Read-only pattern memory for the MEM_LAT=1 instance
  assign mem_rdata_1 = (mem_adr_1 == 32'h4) ? 32'h8C01_0000 : (mem_adr_1 ^ 32'hA5A5_0000);

  // Writable memory for the MEM_LAT=3 instance; unwritten words read a pattern
  logic [31:0] mem3 [16];
  logic [15:0] wvalid = '0;
  int          wr_cnt3 = 0;
  assign mem_rdata_3 = wvalid[mem_adr_3[5:2]] ? mem3[mem_adr_3[5:2]] : (32'h1000_0000 | mem_adr_3);

  always @(posedge clk) begin
    if (mem_write_3) begin
      mem3[mem_adr_3[5:2]]   <= mem_wdata_3;
      wvalid[mem_adr_3[5:2]] <= 1'b1;
      wr_cnt3                <= wr_cnt3 + 1;
    end
  end

  // Mutual exclusion of acks and strobes on every cycle out of reset
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if ((if_ack_1 && d_ack_1) || (mem_read_1 && mem_write_1)) begin
        errors++;
        $display("FAIL excl_u1 acks=%b%b strobes=%b%b required no overlap", if_ack_1, d_ack_1, mem_read_1, mem_write_1);
      end
      checks++;
      if ((if_ack_3 && d_ack_3) || (mem_read_3 && mem_write_3)) begin
        errors++;
        $display("FAIL excl_u3 acks=%b%b strobes=%b%b required no overlap", if_ack_3, d_ack_3, mem_read_3, mem_write_3);
      end
    end
  end

  task automatic test_reset();
    checks++;
    if ({if_ack_1, d_ack_1, mem_read_1, mem_write_1} !== 4'b0) begin
      errors++; $display("FAIL reset_strobes_u1 got %b expected 0000", {if_ack_1, d_ack_1, mem_read_1, mem_write_1});
    end
    checks++;
    if ({mem_adr_1, mem_wdata_1, if_rdata_1, d_rdata_1} !== 128'b0) begin
      errors++; $display("FAIL reset_data_u1 got %h expected 0", {mem_adr_1, mem_wdata_1, if_rdata_1, d_rdata_1});
    end
    @(negedge clk);
    checks++;
    if ({if_ack_3, d_ack_3, mem_read_3, mem_write_3} !== 4'b0) begin
      errors++; $display("FAIL reset_strobes_u3 got %b expected 0000", {if_ack_3, d_ack_3, mem_read_3, mem_write_3});
    end
    checks++;
    if ({mem_adr_3, mem_wdata_3, if_rdata_3, d_rdata_3} !== 128'b0) begin
      errors++; $display("FAIL reset_data_u3 got %h expected 0", {mem_adr_3, mem_wdata_3, if_rdata_3, d_rdata_3});
    end
  endtask

  task automatic test_fetch_lat1();
    @(negedge clk);
    if_req_1 = 1'b1; if_adr_1 = 32'h4;
    @(negedge clk);
    checks++;
    if ({mem_read_1, mem_write_1, if_ack_1} !== 3'b100) begin
      errors++; $display("FAIL fetch_access_strobes got %b expected 100", {mem_read_1, mem_write_1, if_ack_1});
    end
    checks++;
    if (mem_adr_1 !== 32'h4) begin
      errors++; $display("FAIL fetch_access_adr got %h expected 00000004", mem_adr_1);
    end
    @(negedge clk);
    checks++;
    if ({if_ack_1, d_ack_1, mem_read_1} !== 3'b100) begin
      errors++; $display("FAIL fetch_done_ack got %b expected 100", {if_ack_1, d_ack_1, mem_read_1});
    end
    checks++;
    if (if_rdata_1 !== 32'h8C01_0000) begin
      errors++; $display("FAIL fetch_rdata got %h expected 8c010000", if_rdata_1);
    end
    if_req_1 = 1'b0; if_adr_1 = 32'h0;
    @(negedge clk);
    checks++;
    if (if_ack_1 !== 1'b0 || if_rdata_1 !== 32'h8C01_0000 || mem_adr_1 !== 32'h4) begin
      errors++; $display("FAIL fetch_hold got ack=%b rdata=%h adr=%h expected 0/8c010000/00000004", if_ack_1, if_rdata_1, mem_adr_1);
    end
  endtask

  task automatic test_tie_alternation();
    logic who [4];
    int   at  [4];
    int   n   = 0;
    int   cyc = 0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    if_req_1 = 1'b1; if_adr_1 = 32'h20;
    d_req_1  = 1'b1; d_we_1 = 1'b0; d_adr_1 = 32'h40;
    while (n < 4 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (d_ack_1) begin
        who[n] = 1'b1; at[n] = cyc; n++;
        checks++;
        if (d_rdata_1 !== 32'hA5A5_0040) begin
          errors++; $display("FAIL tie_d_rdata got %h expected a5a50040", d_rdata_1);
        end
      end else if (if_ack_1) begin
        who[n] = 1'b0; at[n] = cyc; n++;
        checks++;
        if (if_rdata_1 !== 32'hA5A5_0020) begin
          errors++; $display("FAIL tie_if_rdata got %h expected a5a50020", if_rdata_1);
        end
      end
    end
    if_req_1 = 1'b0; d_req_1 = 1'b0;
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL tie_ack_count got %0d expected 4", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (who[i] !== ((i % 2) == 0)) begin
        errors++; $display("FAIL tie_order idx %0d got d=%b expected d=%b", i, who[i], (i % 2) == 0);
      end
      checks++;
      if (at[i] != 2 + 3 * i) begin
        errors++; $display("FAIL tie_timing idx %0d got cycle %0d expected %0d", i, at[i], 2 + 3 * i);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_write_lat3();
    int base = wr_cnt3;
    @(negedge clk);
    d_req_3 = 1'b1; d_we_3 = 1'b1; d_adr_3 = 32'h10; d_wdata_3 = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if ({mem_read_3, mem_write_3} !== 2'b00 || mem_adr_3 !== 32'h10 || mem_wdata_3 !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_access1 got rw=%b%b adr=%h wd=%h expected 00/00000010/deadbeef", mem_read_3, mem_write_3, mem_adr_3, mem_wdata_3);
    end
    @(negedge clk);
    checks++;
    if ({mem_read_3, mem_write_3, d_ack_3} !== 3'b000) begin
      errors++; $display("FAIL wr_access2 got %b expected 000", {mem_read_3, mem_write_3, d_ack_3});
    end
    @(negedge clk);
    checks++;
    if ({mem_read_3, mem_write_3, d_ack_3} !== 3'b010) begin
      errors++; $display("FAIL wr_access3 got %b expected 010", {mem_read_3, mem_write_3, d_ack_3});
    end
    @(negedge clk);
    checks++;
    if ({mem_write_3, d_ack_3} !== 2'b01) begin
      errors++; $display("FAIL wr_done got write/ack=%b expected 01", {mem_write_3, d_ack_3});
    end
    checks++;
    if (mem3[4] !== 32'hDEAD_BEEF || wr_cnt3 - base != 1) begin
      errors++; $display("FAIL wr_mem got word=%h writes=%0d expected deadbeef/1", mem3[4], wr_cnt3 - base);
    end
    d_req_3 = 1'b0; d_we_3 = 1'b0;
    @(negedge clk);
    checks++;
    if (d_ack_3 !== 1'b0 || wr_cnt3 - base != 1) begin
      errors++; $display("FAIL wr_after got ack=%b writes=%0d expected 0/1", d_ack_3, wr_cnt3 - base);
    end
  endtask

  task automatic test_midaccess_change();
    @(negedge clk);
    if_req_3 = 1'b1; if_adr_3 = 32'h8;
    @(negedge clk);
    checks++;
    if (mem_adr_3 !== 32'h8 || mem_read_3 !== 1'b1) begin
      errors++; $display("FAIL mid_start got adr=%h rd=%b expected 00000008/1", mem_adr_3, mem_read_3);
    end
    if_adr_3 = 32'h30; if_req_3 = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_adr_3 !== 32'h8 || mem_read_3 !== 1'b1) begin
      errors++; $display("FAIL mid_access2 got adr=%h rd=%b expected 00000008/1", mem_adr_3, mem_read_3);
    end
    @(negedge clk);
    checks++;
    if (mem_adr_3 !== 32'h8 || mem_read_3 !== 1'b1 || if_ack_3 !== 1'b0) begin
      errors++; $display("FAIL mid_access3 got adr=%h rd=%b ack=%b expected 00000008/1/0", mem_adr_3, mem_read_3, if_ack_3);
    end
    @(negedge clk);
    checks++;
    if (if_ack_3 !== 1'b1 || if_rdata_3 !== 32'h1000_0008) begin
      errors++; $display("FAIL mid_ack got ack=%b rdata=%h expected 1/10000008", if_ack_3, if_rdata_3);
    end
    checks++;
    if (mem_adr_3 !== 32'h8 || mem_read_3 !== 1'b0) begin
      errors++; $display("FAIL mid_idle_hold got adr=%h rd=%b expected 00000008/0", mem_adr_3, mem_read_3);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    int base = wr_cnt3;
    int cyc  = 0;
    logic seen = 1'b0;
    @(negedge clk);
    d_req_3 = 1'b1; d_we_3 = 1'b1; d_adr_3 = 32'h14; d_wdata_3 = 32'h1234_5678;
    repeat (3) @(negedge clk);
    checks++;
    if (mem_write_3 !== 1'b1) begin
      errors++; $display("FAIL rstw_pre got write=%b expected 1", mem_write_3);
    end
    rst = 1'b0; d_req_3 = 1'b0;
    #1;
    checks++;
    if ({mem_write_3, mem_read_3, d_ack_3} !== 3'b000 || mem_adr_3 !== 32'h0) begin
      errors++; $display("FAIL rstw_async got strobes=%b adr=%h expected 000/00000000", {mem_write_3, mem_read_3, d_ack_3}, mem_adr_3);
    end
    @(negedge clk);
    checks++;
    if (d_ack_3 !== 1'b0 || wr_cnt3 != base || wvalid[5] !== 1'b0) begin
      errors++; $display("FAIL rstw_nowrite got ack=%b writes=%0d valid=%b expected 0/0/0", d_ack_3, wr_cnt3 - base, wvalid[5]);
    end
    rst = 1'b1; d_req_3 = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_adr_3 !== 32'h14 || mem_wdata_3 !== 32'h1234_5678 || mem_write_3 !== 1'b0) begin
      errors++; $display("FAIL rstw_regrant got adr=%h wd=%h wr=%b expected 00000014/12345678/0", mem_adr_3, mem_wdata_3, mem_write_3);
    end
    while (!seen && cyc < 10) begin
      @(negedge clk);
      cyc++;
      seen = d_ack_3;
    end
    d_req_3 = 1'b0; d_we_3 = 1'b0;
    checks++;
    if (!seen || cyc != 3) begin
      errors++; $display("FAIL rstw_ack got seen=%b cycle=%0d expected 1/3", seen, cyc);
    end
    checks++;
    if (wr_cnt3 - base != 1 || mem3[5] !== 32'h1234_5678) begin
      errors++; $display("FAIL rstw_mem got writes=%0d word=%h expected 1/12345678", wr_cnt3 - base, mem3[5]);
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    if_req_1 = 1'b0; if_adr_1 = '0; d_req_1 = 1'b0; d_we_1 = 1'b0; d_adr_1 = '0; d_wdata_1 = '0;
    if_req_3 = 1'b0; if_adr_3 = '0; d_req_3 = 1'b0; d_we_3 = 1'b0; d_adr_3 = '0; d_wdata_3 = '0;
    #1 rst = 1'b0;
    #3;
    test_reset();
    rst = 1'b1;
    test_fetch_lat1();
    test_tie_alternation();
    test_write_lat3();
    test_midaccess_change();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
